// File: rtl/store_pkg.sv
// Shared definitions for the store path and its load-side counterpart.
//   - Access size encodings (shared with the load-side extension logic).
//   - Store FSM state encoding.
//   - size_to_count: maps an access size to the number of bytes written.
//   - is_misaligned: natural-alignment test used when ALIGN_CHECK_EN is defined.
package store_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The reserved encoding 2'b11 behaves as a word.
  function automatic logic [2:0] size_to_count(input logic [1:0] size);
    logic [2:0] cnt;
    case (size)
      SZ_BYTE: cnt = 3'd1;
      SZ_HALF: cnt = 3'd2;
      default: cnt = 3'd4;
    endcase
    return cnt;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/store_narrower_byte_lane_select.sv
// byte_lane_select: picks one little-endian byte lane out of a 32-bit word.
// Ports:
//   word  in  32  source word
//   idx   in  2   lane index (0 = bits 7:0)
//   lane  out 8   selected byte
module byte_lane_select (
  input  logic [31:0] word,
  input  logic [1:0]  idx,
  output logic [7:0]  lane
);

  always_comb begin
    lane = 8'h00;
    case (idx)
      2'd0: lane = word[7:0];
      2'd1: lane = word[15:8];
      2'd2: lane = word[23:16];
      2'd3: lane = word[31:24];
      default: lane = 8'h00;
    endcase
  end

endmodule

// File: rtl/store_narrower.sv
// store_narrower: narrows a 32-bit register operand to byte/halfword/word
// and writes it byte-serially, little-endian, over an 8-bit memory port.
// One request per st_valid/st_ready handshake; each byte is held on the
// memory port until mem_ack; st_done pulses for one cycle at the end.
//
// Optional feature macro: ALIGN_CHECK_EN. When defined, misaligned halfword
// or word requests are accepted but not written, and st_err pulses instead
// of st_done. When undefined, st_err is tied to 0 and misaligned stores are
// written at the given byte addresses.
//
// Ports:
//   clk        in   1       clock, rising edge
//   rst_n      in   1       synchronous active-low reset
//   st_valid   in   1       store request valid
//   st_ready   out  1       ready for a request (IDLE only)
//   st_size    in   2       00 byte, 01 half, 10 word, 11 word
//   st_addr    in   ADDR_W  byte address
//   st_data    in   DATA_W  register value, low-order bytes used
//   mem_we     out  1       byte write request
//   mem_addr   out  ADDR_W  address of current byte
//   mem_wdata  out  8       current byte
//   mem_ack    in   1       memory accepted the byte
//   st_done    out  1       store completed pulse
//   st_err     out  1       store rejected pulse
module store_narrower
  import store_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [1:0]        st_size,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  output logic              st_done,
  output logic              st_err
);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        idx_q;
  logic [2:0]        cnt_q;
  logic              err_q;
  logic              reject;
  logic              last_byte;
  logic [7:0]        lane;

`ifdef ALIGN_CHECK_EN
  assign reject = is_misaligned(st_size, st_addr[1:0]);
`else
  assign reject = 1'b0;
`endif

  assign last_byte = (({1'b0, idx_q} + 3'd1) == cnt_q);

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (st_valid) state_nxt = reject ? DONE : WRITE;
      WRITE:   if (mem_ack && last_byte) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and request registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      data_q <= '0;
      addr_q <= '0;
      idx_q  <= 2'd0;
      cnt_q  <= 3'd0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (st_valid) begin
            data_q <= st_data;
            addr_q <= st_addr;
            cnt_q  <= size_to_count(st_size);
            idx_q  <= 2'd0;
            err_q  <= reject;
          end
        end
        WRITE: begin
          if (mem_ack && !last_byte) idx_q <= idx_q + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  byte_lane_select u_lane (
    .word (data_q[31:0]),
    .idx  (idx_q),
    .lane (lane)
  );

  // Memory port is driven to zero outside WRITE so stale request data
  // never appears on the bus.
  assign st_ready  = (state == IDLE);
  assign mem_we    = (state == WRITE);
  assign mem_addr  = (state == WRITE) ? (addr_q + ADDR_W'(idx_q)) : '0;
  assign mem_wdata = (state == WRITE) ? lane : 8'h00;
  assign st_done   = (state == DONE) && !err_q;

`ifdef ALIGN_CHECK_EN
  assign st_err = (state == DONE) && err_q;
`else
  assign st_err = 1'b0;
`endif

endmodule

// File: tb/tb_store_narrower.sv
// Testbench for store_narrower: directed scenarios plus randomized stores,
// checked against a byte-list model of the store semantics.
module tb_store_narrower;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
`ifdef ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              st_valid = 1'b0;
  logic              st_ready;
  logic [1:0]        st_size = 2'b00;
  logic [ADDR_W-1:0] st_addr = '0;
  logic [DATA_W-1:0] st_data = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack = 1'b0;
  logic              st_done;
  logic              st_err;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;
  int wr_seen = 0;
  int done_exp = 0;
  int wr_exp = 0;

  store_narrower #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_size   (st_size),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .st_done   (st_done),
    .st_err    (st_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      if (st_done) done_seen++;
      if (mem_we && mem_ack) wr_seen++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one store and check every byte it should produce. stall_idx /
  // stall_len force a fixed stall on one byte; other bytes get a random
  // stall of 0..rmax cycles.
  task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                          input int stall_idx, input int stall_len, input int rmax);
    int  n;
    int  stall;
    bit  rej;
    n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    rej = ALIGN && (((sz == 2'b01) && a[0]) || ((sz >= 2'b10) && (a[1:0] != 2'b00)));
    @(negedge clk);
    chk("ready_idle", st_ready, 1);
    st_valid = 1'b1; st_size = sz; st_addr = a; st_data = d;
    @(negedge clk);
    st_valid = 1'b0;
    if (rej) begin
      chk("rej_we", mem_we, 0);
      chk("rej_err", st_err, 1);
      chk("rej_done", st_done, 0);
      @(negedge clk);
      chk("rej_ready", st_ready, 1);
      chk("rej_err_clear", st_err, 0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      stall = (i == stall_idx) ? stall_len : int'($urandom_range(rmax, 0));
      for (int s = 0; s <= stall; s++) begin
        chk("we", mem_we, 1);
        chk("addr", mem_addr, a + i);
        chk("wdata", {24'h0, mem_wdata}, (d >> (8 * i)) & 32'hFF);
        chk("ready_busy", st_ready, 0);
        chk("done_early", st_done, 0);
        mem_ack = (s == stall);
        @(negedge clk);
      end
      mem_ack = 1'b0;
      wr_exp++;
    end
    chk("done_we", mem_we, 0);
    chk("done", st_done, 1);
    chk("done_err", st_err, 0);
    done_exp++;
    @(negedge clk);
    chk("done_clear", st_done, 0);
    chk("ready_back", st_ready, 1);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", st_ready, 1);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", {24'h0, mem_wdata}, 0);
    chk("rst_done", st_done, 0);
    chk("rst_err", st_err, 0);
    rst_n = 1'b1;

    // Directed stores
    do_store(2'b00, 32'h0000_0100, 32'hDEAD_BEEF, -1, 0, 0);
    do_store(2'b10, 32'h0000_0200, 32'h1122_3344, 1, 3, 0);
    do_store(2'b01, 32'hFFFF_FFFF, 32'h0000_ABCD, -1, 0, 0);
    do_store(2'b10, 32'h0000_0202, 32'hCAFE_F00D, -1, 0, 0);
    do_store(2'b11, 32'h0000_0500, 32'h8899_AABB, 2, 1, 0);

    // Reset in the middle of a word store
    @(negedge clk);
    st_valid = 1'b1; st_size = 2'b10; st_addr = 32'h300; st_data = 32'hA1B2_C3D4;
    @(negedge clk);
    st_valid = 1'b0;
    chk("rm_b0", {24'h0, mem_wdata}, 32'hD4);
    mem_ack = 1'b1;
    @(negedge clk);
    chk("rm_b1", {24'h0, mem_wdata}, 32'hC3);
    @(negedge clk);
    chk("rm_addr2", mem_addr, 32'h302);
    mem_ack = 1'b0;
    rst_n = 1'b0;
    wr_exp += 2;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rm_we", mem_we, 0);
    chk("rm_ready", st_ready, 1);
    chk("rm_done", st_done, 0);
    chk("rm_addr", mem_addr, 0);
    @(negedge clk);
    chk("rm_we_after", mem_we, 0);
    chk("rm_done_after", st_done, 0);
    do_store(2'b00, 32'h0000_0310, 32'h0000_005A, -1, 0, 0);

    // Back-to-back with st_valid held high
    @(negedge clk);
    chk("bb_ready0", st_ready, 1);
    st_valid = 1'b1; st_size = 2'b00; st_addr = 32'h400; st_data = 32'h1234_5655;
    @(negedge clk);
    chk("bb_we0", mem_we, 1);
    chk("bb_addr0", mem_addr, 32'h400);
    chk("bb_data0", {24'h0, mem_wdata}, 32'h55);
    mem_ack = 1'b1;
    st_addr = 32'h401; st_data = 32'h9988_7766;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("bb_done0", st_done, 1);
    chk("bb_we_d0", mem_we, 0);
    chk("bb_ready_d0", st_ready, 0);
    @(negedge clk);
    chk("bb_ready1", st_ready, 1);
    chk("bb_done_gap", st_done, 0);
    @(negedge clk);
    st_valid = 1'b0;
    chk("bb_we1", mem_we, 1);
    chk("bb_addr1", mem_addr, 32'h401);
    chk("bb_data1", {24'h0, mem_wdata}, 32'h66);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("bb_done1", st_done, 1);
    @(negedge clk);
    chk("bb_ready2", st_ready, 1);
    chk("bb_we_idle", mem_we, 0);
    done_exp += 2;
    wr_exp += 2;

    // Randomized stores
    for (int k = 0; k < 24; k++) begin
      do_store(2'($urandom_range(3, 0)), $urandom, $urandom, -1, 0, 2);
    end

    // Stray ack while idle must not cause a write
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("idle_ack_we", mem_we, 0);

    @(negedge clk);
    chk("done_total", done_seen, done_exp);
    chk("write_total", wr_seen, wr_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_narrower.md
Name: store_narrower

Overview:
- Store-path counterpart of the load-side sign extension: narrows a 32-bit register value to byte, halfword or word (SB/SH/SW) and writes it byte-serially over an 8-bit memory write port.
- Sits between the datapath's store control and a byte-wide data memory.
- Accepts one store request per valid/ready handshake.
- Emits little-endian bytes with a per-byte ack handshake, then pulses done.

Parameters:
- ADDR_W, 32, width of the byte address.
- DATA_W, 32, width of the register store operand (fixed at 32; the parameter is for documentation only).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- st_valid  input  1  store request valid.
- st_ready  output  1  block can accept a request (high only in IDLE).
- st_size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved (treated as word).
- st_addr  input  ADDR_W  byte address of the store.
- st_data  input  DATA_W  register value to store; low-order bytes are used.
- mem_we  output  1  byte write request valid.
- mem_addr  output  ADDR_W  byte address of the current byte.
- mem_wdata  output  8  current byte.
- mem_ack  input  1  memory accepted the byte this cycle (meaningful only while mem_we=1).
- st_done  output  1  one-cycle pulse: store completed.
- st_err  output  1  one-cycle pulse: store rejected (ALIGN_CHECK_EN only; otherwise tied to 0).

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state goes to IDLE.
  - Outputs: st_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, st_done=0, st_err=0.
  - Internal registers (latched data, address, byte index, byte count) clear to 0.
  - Reset mid-transfer abandons the transfer. No further bytes are issued and no done pulse is produced.
- States: IDLE, WRITE, DONE.
- IDLE:
  - st_ready=1.
  - When st_valid=1, latch st_data, st_addr and st_size.
  - Set byte count: 1 for byte, 2 for halfword, 4 for word or reserved.
  - Clear byte index to 0 and move to WRITE.
  - st_ready=0 from the next cycle.
- WRITE:
  - mem_we=1, mem_addr = latched_addr + index, mem_wdata = latched_data[8*index+7 : 8*index].
  - Address arithmetic wraps modulo 2^ADDR_W (for example, 0xFFFF_FFFF + 1 = 0x0000_0000).
  - mem_addr and mem_wdata stay stable while mem_ack=0; stalls of any length are allowed.
  - On mem_ack=1: if index == count-1, go to DONE; otherwise index increments and the next byte appears on the following cycle.
  - Minimum latency: count cycles in WRITE plus 1 cycle in DONE.
- DONE:
  - st_done=1 for exactly one cycle, mem_we=0, then return to IDLE.
  - st_ready rises the cycle after DONE.
  - A st_valid held high then is accepted on that cycle.
- Requests arriving while st_ready=0 are ignored and not queued. Upstream must hold st_valid until it sees st_ready.
- Bytes above the selected size are never written. Upper bits of st_data are ignored, which is the inverse of load sign/zero extension.
- mem_ack while mem_we=0 is ignored.

Optional Feature:
- Macro: ALIGN_CHECK_EN.
- Defined:
  - In IDLE, a request is misaligned if it is a halfword with st_addr[0]=1, or a word/reserved size with st_addr[1:0]≠00.
  - A misaligned request is accepted (st_ready handshake completes) and sends the block to DONE with no WRITE cycles.
  - In that DONE cycle st_err=1 and st_done=0.
  - mem_we never rises for the rejected request.
- Undefined:
  - No check is made; misaligned stores are written byte-by-byte at the given addresses.
  - st_err is tied to 0.

Decomposition:
- Shared package (store_pkg):
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - State encoding IDLE/WRITE/DONE.
  - A function mapping size to byte count.
  - Load-side extension logic reuses the size encodings.
- One natural sub-module, byte_lane_select: combinational 32-bit word plus 2-bit index in, 8-bit byte out.

Test Plan:
- SB: st_size=00, st_addr=0x100, st_data=0xDEADBEEF, mem_ack always 1 -> exactly one byte 0xEF written at 0x100; st_done pulses 2 cycles after acceptance.
- SW with stalls: st_size=10, addr 0x200, data 0x11223344, mem_ack low for 3 cycles on byte 1 -> writes 0x44@0x200, 0x33@0x201, 0x22@0x202, 0x11@0x203; addr/data stable during the stall; one st_done.
- SH wrap: st_size=01, addr 0xFFFF_FFFF, data 0x0000ABCD, no ALIGN_CHECK_EN -> 0xCD@0xFFFF_FFFF, then 0xAB@0x0000_0000.
- Misaligned with ALIGN_CHECK_EN: SW at 0x202 -> mem_we never asserted; st_err pulses once; st_done stays 0; st_ready returns 1.
- Reset mid-op: SW started, rst_n=0 after the second byte is acked -> next cycle mem_we=0, st_ready=1, no st_done; a following SB completes normally.
- Back-to-back: st_valid held high with two SB requests -> second accepted on the cycle after DONE; exactly two st_done pulses; no byte dropped or duplicated.
